// File: rtl/hex_display_pkg.sv
// Shared constants and types for the multiplexed hex display scheduler.
package hex_display_pkg;

  // Active-low pattern with every segment off.
  localparam logic [6:0] BLANK_PATTERN = 7'h7F;

  // Number of displays served by one scheduler.
  localparam int NUM_DIGITS = 4;

  // Width of the digit index (0..NUM_DIGITS-1).
  localparam int IDX_W = 2;

  // Scan FSM states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LATCH = 2'd2
  } scan_state_e;

  // One shadow register file entry.
  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } shadow_t;

endpackage

// File: rtl/hex_display_scheduler_segment.sv
// Combinational hex nibble to 7-segment decoder, active-low, bit0 = segment a.
module segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Standard hex glyph table (segments g..a, low = lit).
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-multiplexed hex display scheduler: a shadow register file is written
// through a valid/ready port, and one shared decoder refreshes one display
// per scan slot.
//
// Handshake: an update transfers on a rising edge where wr_valid and wr_ready
// are both 1. wr_ready does not depend on wr_valid. While wr_valid=1 and
// wr_ready=0 the requester holds wr_digit/wr_value/wr_blank stable.
// wr_ready is 0 in reset and in the LOAD state, 1 otherwise.
module hex_display_scheduler
  import hex_display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_digit,
  input  logic [3:0]       wr_value,
  input  logic             wr_blank,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic             scan_tick,
  output logic [1:0]       dbg_state
);

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  scan_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  shadow_t          shadow_q [NUM_DIGITS];
  logic [6:0]       hex_q    [NUM_DIGITS];
  shadow_t          cur_entry;
  logic [6:0]       dec_out;
  logic             wr_fire;

  // Slot boundary: last count of the prescaler.
  assign scan_tick = (cnt_q == CNT_LAST);

  // Updates are refused during reset and while the decoder input is being set up.
  assign wr_ready  = resetn && (state_q != ST_LOAD);
  assign wr_fire   = wr_valid && wr_ready;

  // The single shared decoder always looks at the entry of the current digit.
  assign cur_entry = shadow_q[idx_q];

  segment u_segment (
    .hex (cur_entry.value),
    .seg (dec_out)
  );

  // Prescaler counting 0..SCAN_DIV-1 and wrapping.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (scan_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Scan FSM and digit index; index starts at 3 so digit 0 is served first.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_W'(3);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_tick) begin
            state_q <= ST_LOAD;
            idx_q   <= idx_q + 1'b1;
          end
        end
        ST_LOAD:  state_q <= ST_LATCH;
        ST_LATCH: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Shadow register file write port.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '{blank: 1'b1, value: 4'h0};
      end
    end else if (wr_fire) begin
      shadow_q[wr_digit] <= '{blank: wr_blank, value: wr_value};
    end
  end

  // Output registers; only the digit being served changes, and it samples
  // the shadow before any write landing on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_q[i] <= BLANK_PATTERN;
      end
    end else if (state_q == ST_LATCH) begin
      hex_q[idx_q] <= cur_entry.blank ? BLANK_PATTERN : dec_out;
    end
  end

  assign HEX0      = hex_q[0];
  assign HEX1      = hex_q[1];
  assign HEX2      = hex_q[2];
  assign HEX3      = hex_q[3];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler with a short scan slot.
module tb_hex_display_scheduler;
  import hex_display_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int LAT      = 4 * SCAN_DIV + 2;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       resetn;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_value;
  logic       wr_blank;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       scan_tick;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hex_display_scheduler #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(4)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_digit  (wr_digit),
    .wr_value  (wr_value),
    .wr_blank  (wr_blank),
    .HEX0      (hex0),
    .HEX1      (hex1),
    .HEX2      (hex2),
    .HEX3      (hex3),
    .scan_tick (scan_tick),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         vectors = 0;
  int         errors  = 0;
  logic [8:0] exp_q[$];     // {digit, expected pattern}
  logic [6:0] exp_hex [4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_model(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [6:0] get_hex(input int d);
    case (d)
      0:       return hex0;
      1:       return hex1;
      2:       return hex2;
      default: return hex3;
    endcase
  endfunction

  task automatic compare_all(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_hex%0d", tag, d), get_hex(d), exp_hex[d]);
    end
  endtask

  // Wait out the worst-case update latency, then retire every queued write.
  task automatic drain(input string tag);
    logic [8:0] e;
    repeat (LAT) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_hex[e[8:7]] = e[6:0];
    end
    compare_all(tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [1:0] d, input logic [3:0] v, input logic b, output int waits);
    wr_valid = 1'b1;
    wr_digit = d;
    wr_value = v;
    wr_blank = b;
    waits    = 0;
    #1;
    while (!wr_ready && waits < 8) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("wr_accept", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    exp_q.push_back({d, b ? 7'h7F : seg_model(v)});
  endtask

  task automatic wait_state(input logic [1:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (dbg_state == s) ok = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bit ok;
    for (int d = 0; d < 4; d++) exp_hex[d] = 7'h7F;
    resetn   = 1'b0;
    // A write presented during reset must be dropped.
    wr_valid = 1'b1;
    wr_digit = 2'd0;
    wr_value = 4'h8;
    wr_blank = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", wr_ready, 0);
    check("rst_tick", scan_tick, 0);
    check("rst_state", dbg_state, ST_IDLE);
    compare_all("rst");

    // Release and idle: tick every 4th cycle, ready low only in the LOAD cycle.
    @(negedge clk);
    resetn   = 1'b1;
    wr_valid = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("idle_tick_c%0d", c), scan_tick, (c % 4 == 3));
      check($sformatf("idle_ready_c%0d", c), wr_ready, !(c % 4 == 0 && c > 0));
    end
    compare_all("idle");

    // Single write: digit 0 shows 8.
    wr(2'd0, 4'h8, 1'b0, w);
    drain("w8");

    // Back-to-back writes to all digits.
    for (int d = 0; d < 4; d++) wr(2'(d), 4'(d + 1), 1'b0, w);
    drain("b2b");

    // Write presented during LOAD stalls exactly one cycle.
    wait_state(ST_LOAD, ok);
    check("reach_load", ok, 1);
    wr(2'd1, 4'h5, 1'b0, w);
    check("load_stall_cycles", w, 1);
    drain("stall");

    // Digit 2 shows A, then gets blanked.
    wr(2'd2, 4'hA, 1'b0, w);
    drain("d2a");
    wr(2'd2, 4'h3, 1'b1, w);
    drain("d2blank");

    // Reset in LATCH: everything blanks and digit 0 is served first.
    wait_state(ST_LATCH, ok);
    check("reach_latch", ok, 1);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    exp_q.delete();
    for (int d = 0; d < 4; d++) exp_hex[d] = 7'h7F;
    check("rst2_ready", wr_ready, 0);
    check("rst2_state", dbg_state, ST_IDLE);
    compare_all("rst2");
    resetn = 1'b1;
    for (int d = 0; d < 4; d++) wr(2'(d), 4'(d), 1'b0, w);
    @(negedge clk);
    #1;
    check("rst2_c5_hex0", hex0, 7'h7F);
    @(negedge clk);
    #1;
    check("rst2_c6_hex0", hex0, 7'h40);
    check("rst2_c6_hex1", hex1, 7'h7F);
    check("rst2_c6_hex2", hex2, 7'h7F);
    check("rst2_c6_hex3", hex3, 7'h7F);
    drain("rst2_all");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
